// File: rtl/stopwatch_if.sv
// Stopwatch controller signal bundle: button/tick inputs, live BCD digits in,
// count-enable, clear, display digits and status out.
interface stopwatch_if;
  logic       en10ms;
  logic       ss;
  logic       lap;
  logic [3:0] csec1;
  logic [3:0] csec10;
  logic [3:0] sec1;
  logic [3:0] sec10;
  logic [3:0] min1;
  logic [3:0] min10;
  logic       cnt_en;
  logic       clr;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] d4;
  logic [3:0] d5;
  logic       running;
  logic       lap_shown;

  modport master (
    output en10ms, ss, lap, csec1, csec10, sec1, sec10, min1, min10,
    input  cnt_en, clr, d0, d1, d2, d3, d4, d5, running, lap_shown
  );

  modport slave (
    input  en10ms, ss, lap, csec1, csec10, sec1, sec10, min1, min10,
    output cnt_en, clr, d0, d1, d2, d3, d4, d5, running, lap_shown
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop/lap handling, lap freeze with auto-release,
// STOP blink, leading-zero blanking and a registered six-digit display.
module stopwatch_ctrl #(
  parameter int LAP_HOLD_TICKS = 300,
  parameter int BLINK_TICKS    = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  stopwatch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;
  typedef logic [5:0][3:0] digits_t;

  localparam logic [3:0] BLANK   = 4'hA;
  localparam int         HOLD_W  = $clog2(LAP_HOLD_TICKS + 1);
  localparam int         BLINK_W = $clog2(BLINK_TICKS + 1);

  state_t               state_q, state_d;
  logic                 clr_d, latch_en, hold_last;
  logic [HOLD_W-1:0]    hold_q;
  logic [BLINK_W-1:0]   blink_q;
  logic                 blank_q;
  logic                 clr_q, running_q, lap_shown_q;
  digits_t              live, lap_dig_q, src, disp_p1;

  // MIN10 = 0 blanks D5; MIN10 = MIN1 = 0 also blanks D4.
  function automatic digits_t lead_blank(input digits_t dig);
    digits_t r;
    r = dig;
    if (dig[5] == 4'd0) begin
      r[5] = BLANK;
      if (dig[4] == 4'd0) r[4] = BLANK;
    end
    return r;
  endfunction

  assign live      = {bus.min10, bus.min1, bus.sec10, bus.sec1, bus.csec10, bus.csec1};
  assign hold_last = (hold_q >= HOLD_W'(LAP_HOLD_TICKS - 1));

  always_comb begin
    state_d  = state_q;
    clr_d    = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      IDLE: if (bus.ss) state_d = RUN;
      RUN: begin
        if (bus.ss) state_d = STOP;
        else if (bus.lap) begin
          state_d  = LAP;
          latch_en = 1'b1;
        end
      end
      LAP: begin
        if (bus.ss)                         state_d = STOP;
        else if (bus.lap)                   state_d = RUN;
        else if (bus.en10ms && hold_last)   state_d = RUN;
      end
      STOP: begin
        if (bus.ss) state_d = RUN;
        else if (bus.lap) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clr_q       <= 1'b0;
      running_q   <= 1'b0;
      lap_shown_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      running_q   <= (state_d == RUN) || (state_d == LAP);
      lap_shown_q <= (state_d == LAP);
    end
  end

  // Hold counter only lives in LAP, so any other state leaves it at zero for the next entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (state_q != LAP) begin
      hold_q <= '0;
    end else if (bus.en10ms && (hold_q != HOLD_W'(LAP_HOLD_TICKS))) begin
      hold_q <= hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
      blank_q <= 1'b0;
    end else if (state_q != STOP) begin
      blink_q <= '0;
      blank_q <= 1'b0;
    end else if (bus.en10ms) begin
      if (blink_q == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_q <= '0;
        blank_q <= ~blank_q;
      end else begin
        blink_q <= blink_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lap_dig_q <= '0;
    else if (latch_en) lap_dig_q <= live;
  end

  assign src = (state_q == LAP) ? lap_dig_q : live;

  // Display register stage (p1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             disp_p1 <= {BLANK, BLANK, 4'd0, 4'd0, 4'd0, 4'd0};
    else if ((state_q == STOP) && blank_q)  disp_p1 <= {6{BLANK}};
    else                                    disp_p1 <= lead_blank(src);
  end

  assign bus.cnt_en    = bus.en10ms && ((state_q == RUN) || (state_q == LAP));
  assign bus.clr       = clr_q;
  assign bus.running   = running_q;
  assign bus.lap_shown = lap_shown_q;
  assign bus.d0        = disp_p1[0];
  assign bus.d1        = disp_p1[1];
  assign bus.d2        = disp_p1[2];
  assign bus.d3        = disp_p1[3];
  assign bus.d4        = disp_p1[4];
  assign bus.d5        = disp_p1[5];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a per-cycle vector table plus sequences
// for reset abort, tick counting, lap auto-release and STOP blinking.
module tb_stopwatch_ctrl;

  typedef struct {
    logic        ss;
    logic        lap;
    logic        en;
    logic [23:0] dig;
    logic        cnt_en;
    logic        clr;
    logic        running;
    logic        lap_shown;
    logic [23:0] d;
  } vec_t;

  logic clk;
  logic rst_n;
  logic cnt_en_now;
  int   pass_cnt;
  int   total_cnt;
  int   nvec;
  int   pulses;
  vec_t vecs [32];

  stopwatch_if sw ();

  stopwatch_ctrl #(.LAP_HOLD_TICKS(300), .BLINK_TICKS(25)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [23:0] dout();
    return {sw.d5, sw.d4, sw.d3, sw.d2, sw.d1, sw.d0};
  endfunction

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic set_dig(input logic [23:0] h);
    sw.min10  = h[23:20];
    sw.min1   = h[19:16];
    sw.sec10  = h[15:12];
    sw.sec1   = h[11:8];
    sw.csec10 = h[7:4];
    sw.csec1  = h[3:0];
  endtask

  // One clock: inputs applied at negedge, cnt_en sampled then, registers sampled #1 after posedge.
  task automatic cyc(input logic s, input logic l, input logic e);
    @(negedge clk);
    sw.ss = s; sw.lap = l; sw.en10ms = e;
    #1 cnt_en_now = sw.cnt_en;
    @(posedge clk);
    #1;
    sw.ss = 1'b0; sw.lap = 1'b0; sw.en10ms = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sw.ss = 1'b0; sw.lap = 1'b0; sw.en10ms = 1'b0;
    set_dig(24'h000000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add(input logic s, input logic l, input logic e, input logic [23:0] dg,
                     input logic ce, input logic cl, input logic rn, input logic ls,
                     input logic [23:0] d);
    vecs[nvec].ss = s;       vecs[nvec].lap = l;     vecs[nvec].en = e;
    vecs[nvec].dig = dg;     vecs[nvec].cnt_en = ce; vecs[nvec].clr = cl;
    vecs[nvec].running = rn; vecs[nvec].lap_shown = ls; vecs[nvec].d = d;
    nvec++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    nvec      = 0;
    //   ss lap en  digits       cnt clr run ls  display
    add(0, 0, 0, 24'h000000,  0,  0,  0,  0, 24'hAA0000);
    add(0, 1, 0, 24'h000000,  0,  0,  0,  0, 24'hAA0000);
    add(1, 0, 0, 24'h000000,  0,  0,  1,  0, 24'hAA0000);
    add(0, 0, 1, 24'h000001,  1,  0,  1,  0, 24'hAA0001);
    add(0, 0, 0, 24'h012345,  0,  0,  1,  0, 24'hA12345);
    add(0, 1, 0, 24'h012345,  0,  0,  1,  1, 24'hA12345);
    add(0, 0, 1, 24'h013000,  1,  0,  1,  1, 24'hA12345);
    add(0, 0, 0, 24'h013000,  0,  0,  1,  1, 24'hA12345);
    add(0, 1, 0, 24'h013000,  0,  0,  1,  0, 24'hA12345);
    add(0, 0, 0, 24'h013000,  0,  0,  1,  0, 24'hA13000);
    add(1, 1, 1, 24'h020000,  1,  0,  0,  0, 24'hA20000);
    add(0, 0, 1, 24'h020000,  0,  0,  0,  0, 24'hA20000);
    add(0, 1, 0, 24'h020000,  0,  1,  0,  0, 24'hA20000);
    add(0, 0, 0, 24'h020000,  0,  0,  0,  0, 24'hA20000);
    add(0, 1, 0, 24'h020000,  0,  0,  0,  0, 24'hA20000);
    add(0, 0, 0, 24'h100000,  0,  0,  0,  0, 24'h100000);
    add(0, 0, 0, 24'h00C9FE,  0,  0,  0,  0, 24'hAAC9FE);
    add(0, 0, 0, 24'hF00000,  0,  0,  0,  0, 24'hF00000);
    add(0, 0, 0, 24'h0A0000,  0,  0,  0,  0, 24'hAA0000);
    add(1, 0, 1, 24'h000000,  0,  0,  1,  0, 24'hAA0000);
    add(0, 0, 1, 24'h000000,  1,  0,  1,  0, 24'hAA0000);

    // Reset values, with a tick present to show cnt_en stays low.
    rst_n = 1'b0;
    sw.ss = 1'b0; sw.lap = 1'b0; sw.en10ms = 1'b1;
    set_dig(24'h000000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_d", dout(), 24'hAA0000);
    chk("reset_running", 24'(sw.running), 24'h0);
    chk("reset_lap_shown", 24'(sw.lap_shown), 24'h0);
    chk("reset_clr", 24'(sw.clr), 24'h0);
    chk("reset_cnt_en", 24'(sw.cnt_en), 24'h0);
    sw.en10ms = 1'b0;
    rst_n = 1'b1;

    // First SS right after release is taken; five ticks give five enables, D0 tracks CSEC1.
    cyc(1, 0, 0);
    chk("first_ss_running", 24'(sw.running), 24'h1);
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      sw.csec1 = 4'(i);
      cyc(0, 0, 1);
      if (cnt_en_now) pulses++;
      chk("d0_follows_csec1", 24'(sw.d0), 24'(i));
      cyc(0, 0, 0);
      if (cnt_en_now) pulses++;
    end
    chk("cnt_en_pulses", 24'(pulses), 24'd5);

    // Reset in the middle of a CLR pulse.
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("clr_before_abort", 24'(sw.clr), 24'h1);
    #2 rst_n = 1'b0;
    #1 chk("clr_async_abort", 24'(sw.clr), 24'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("no_clr_after_release", 24'(sw.clr), 24'h0);

    // Reset in the middle of a lap freeze.
    set_dig(24'h012345);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("lap_before_abort", 24'(sw.lap_shown), 24'h1);
    #2 rst_n = 1'b0;
    #1 chk("lap_async_abort", 24'(sw.lap_shown), 24'h0);
    chk("lap_abort_d", dout(), 24'hAA0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_dig(24'h013000);
    cyc(0, 0, 0);
    chk("after_abort_live", dout(), 24'hA13000);
    chk("after_abort_clr", 24'(sw.clr), 24'h0);

    // Table-driven vectors from a clean IDLE.
    do_reset();
    for (int v = 0; v < nvec; v++) begin
      set_dig(vecs[v].dig);
      cyc(vecs[v].ss, vecs[v].lap, vecs[v].en);
      chk($sformatf("vec%0d_cnt_en", v), 24'(cnt_en_now), 24'(vecs[v].cnt_en));
      chk($sformatf("vec%0d_clr", v), 24'(sw.clr), 24'(vecs[v].clr));
      chk($sformatf("vec%0d_running", v), 24'(sw.running), 24'(vecs[v].running));
      chk($sformatf("vec%0d_lap_shown", v), 24'(sw.lap_shown), 24'(vecs[v].lap_shown));
      chk($sformatf("vec%0d_d", v), dout(), vecs[v].d);
    end

    // Lap freeze released automatically on the 300th tick.
    do_reset();
    set_dig(24'h012345);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    set_dig(24'h013000);
    pulses = 0;
    for (int t = 1; t <= 300; t++) begin
      cyc(0, 0, 1);
      if (cnt_en_now) pulses++;
      if (t == 299) begin
        chk("hold_299_lap_shown", 24'(sw.lap_shown), 24'h1);
        chk("hold_299_d", dout(), 24'hA12345);
      end
      if (t == 300) begin
        chk("hold_300_lap_shown", 24'(sw.lap_shown), 24'h0);
        chk("hold_300_running", 24'(sw.running), 24'h1);
      end else begin
        cyc(0, 0, 0);
      end
    end
    chk("hold_cnt_en_pulses", 24'(pulses), 24'd300);
    cyc(0, 0, 0);
    chk("hold_release_live", dout(), 24'hA13000);

    // STOP blinking: ticks counted 25..49 blank, otherwise live.
    set_dig(24'h012345);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("blink_n0", dout(), 24'hA12345);
    for (int n = 1; n <= 75; n++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      if (n <= 50)
        chk($sformatf("blink_n%0d", n), dout(),
            (n >= 25 && n < 50) ? 24'hAAAAAA : 24'hA12345);
    end
    chk("blink_n75_blank", dout(), 24'hAAAAAA);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("stop_to_run_visible", dout(), 24'hA12345);
    chk("stop_to_run_running", 24'(sw.running), 24'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter LAP_HOLD_TICKS, default 300, number of EN10MS ticks a frozen lap display is held before automatic release (3 s).
REQ-002 Parameter BLINK_TICKS, default 25, number of EN10MS ticks per blink half-period in STOP (250 ms on / 250 ms off).
REQ-003 CLK  input  1  system clock, 50 MHz.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 EN10MS  input  1  one-cycle 10 ms tick from the tick generator.
REQ-006 SS  input  1  debounced one-cycle start/stop button pulse.
REQ-007 LAP  input  1  debounced one-cycle lap/reset button pulse.
REQ-008 CSEC1, CSEC10, SEC1, SEC10, MIN1, MIN10  input  4 each  live BCD digits from the centisecond, second and minute counters.
REQ-009 CNT_EN  output  1  gated count enable to the centisecond counter.
REQ-010 CLR  output  1  one-cycle synchronous clear pulse to all counters.
REQ-011 D0..D5  output  4 each  display digits to the decoders (D0=CSEC1, D1=CSEC10, D2=SEC1, D3=SEC10, D4=MIN1, D5=MIN10); 4'hA = blank.
REQ-012 RUNNING  output  1  high in RUN and LAP states.
REQ-013 LAP_SHOWN  output  1  high while the display is frozen.

Function
REQ-014 FSM states: IDLE, RUN, LAP, STOP; exactly one SS/LAP event is acted on per cycle.
REQ-015 IDLE: SS -> RUN; LAP ignored.
REQ-016 RUN: SS -> STOP; LAP -> LAP, with all six input digits latched in that same cycle.
REQ-017 LAP: SS -> STOP (freeze released); LAP -> RUN (freeze released); hold counter reaching LAP_HOLD_TICKS -> RUN.
REQ-018 STOP: SS -> RUN; LAP -> IDLE, with CLR asserted for exactly the next cycle.
REQ-019 SS and LAP high in the same cycle: SS takes priority and LAP is discarded.
REQ-020 CNT_EN = EN10MS AND (state is RUN or LAP); combinational, zero latency, so counting continues during a lap freeze.
REQ-021 Hold counter: cleared on entry to LAP; increments on EN10MS while in LAP; saturates; cleared in every other state.
REQ-022 Blink counter: counts EN10MS only in STOP and toggles a blank phase every BLINK_TICKS ticks; on entry to STOP it is cleared to the visible phase.
REQ-023 Display source is the latched digits in LAP and the live inputs in all other states.
REQ-024 Blanking on the selected source: D5 = 4'hA when MIN10 = 0; D4 = 4'hA when MIN10 = 0 and MIN1 = 0; D0..D3 are never zero-blanked.
REQ-025 In STOP during the blank phase, all of D0..D5 = 4'hA.
REQ-026 D0..D5 are registered with one-cycle latency from the selected source.
REQ-027 LAP_SHOWN and RUNNING are registered and decoded from the next state, so they change in the same edge as the state.
REQ-028 Digit inputs are used unchecked; values above 9 pass through unchanged except where REQ-024 applies.

Reset
REQ-029 While RST = 0, asynchronously: state IDLE, CLR 0, RUNNING 0, LAP_SHOWN 0, hold and blink counters 0, lap latch all 0, D0..D3 = 0, D4 = D5 = 4'hA.
REQ-030 CNT_EN is 0 while RST = 0.
REQ-031 Reset asserted mid-LAP or mid-CLR pulse aborts the operation; no CLR is produced after reset release.
REQ-032 First SS after reset release is accepted in the cycle immediately following release.

Verification
REQ-033 Reset, then SS pulse, then 5 EN10MS ticks -> RUNNING = 1, exactly 5 CNT_EN pulses; D0 follows CSEC1 one cycle later.
REQ-034 RUN, inputs 0,1:23.45 (MIN10..CSEC1); LAP pulse; inputs change to 01:30.00 -> D outputs hold {A,1,2,3,4,5} (D5..D0), LAP_SHOWN = 1, CNT_EN still pulses.
REQ-035 In LAP, apply 300 EN10MS ticks with no button -> returns to RUN on the 300th tick, LAP_SHOWN = 0, D shows live digits.
REQ-036 STOP, then LAP pulse -> state IDLE, CLR high for exactly one cycle; a second LAP in IDLE -> no CLR.
REQ-037 In RUN, SS and LAP in the same cycle -> STOP, no digit latch, LAP_SHOWN = 0.
REQ-038 STOP for 50 ticks -> D0..D5 all 4'hA for ticks 25-49 and live otherwise; SS -> RUN with display visible immediately.
